// File: rtl/upc_serial_tx.sv
// upc_serial_tx: serialises one {U,P,C} item code plus its security mark bit
// into a 7-bit frame (START, M, C, P, U, even PAR, STOP) on a one-wire line.
// Input side is a valid/ready handshake; every output comes straight from a flop.
module upc_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       upc_in,
  input  logic             mark_in,
  input  logic             send_valid,
  output logic             send_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  // Divider needs at least one bit even when each frame bit is a single cycle.
  localparam int              DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         bit_q, bit_d;
  logic [4:0]         shreg_q, shreg_d;   // {PAR,U,P,C,M}, shifted out LSB first
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_end;

  assign bit_end = (div_q == DIV_LAST);

  // Next-state logic: tx_d is the value the line takes for the coming bit, so
  // the line changes on the same edge that moves the FSM into that bit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (send_valid) begin
          state_d = S_START;
          tx_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          shreg_d = {^{upc_in, mark_in}, upc_in, mark_in};
        end
      end
      S_START: begin
        div_d = bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        div_d = bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          // After the fourth data bit the parity bit is next in the shifter.
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (bit_q == 2'd3) state_d = S_PARITY;
          else               bit_d   = bit_q + 2'd1;
        end
      end
      S_PARITY: begin
        div_d = bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        div_d = bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset drops tx high immediately, mid-frame or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx          = tx_q;
  assign send_ready  = ready_q;
  assign busy        = ~ready_q;
  assign frames_sent = cnt_q;

endmodule

// File: tb/tb_upc_serial_tx.sv
// Bench for upc_serial_tx: two instances (4 clocks/bit and 1 clock/bit) sharing
// one reset. Expected line waveforms are built from the frame definition
// (bit list START,M,C,P,U,PAR,STOP with parity from a ones count).
module tb_upc_serial_tx;
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] a_upc, b_upc;
  logic a_mark, b_mark, a_valid, b_valid;
  logic a_ready, a_tx, a_busy, b_ready, b_tx, b_busy;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  always #5 clk = ~clk;

  upc_serial_tx #(.CLKS_PER_BIT(CPB_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(rst_n), .upc_in(a_upc), .mark_in(a_mark),
    .send_valid(a_valid), .send_ready(a_ready), .tx(a_tx), .busy(a_busy),
    .frames_sent(a_cnt));

  upc_serial_tx #(.CLKS_PER_BIT(CPB_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset(rst_n), .upc_in(b_upc), .mark_in(b_mark),
    .send_valid(b_valid), .send_ready(b_ready), .tx(b_tx), .busy(b_busy),
    .frames_sent(b_cnt));

  // Line bits in transmit order: index 0 is START, index 6 is STOP.
  function automatic logic [6:0] line_bits(input logic [2:0] u, input logic m);
    logic par;
    par = (($countones({u, m}) % 2) == 1);
    return {1'b1, par, u[2], u[1], u[0], m, 1'b0};
  endfunction

  function automatic logic tx_of(input bit sel);    return sel ? b_tx : a_tx;       endfunction
  function automatic logic ready_of(input bit sel); return sel ? b_ready : a_ready; endfunction
  function automatic logic busy_of(input bit sel);  return sel ? b_busy : a_busy;   endfunction
  function automatic logic [CNT_W-1:0] cnt_of(input bit sel); return sel ? b_cnt : a_cnt; endfunction

  task automatic drive(input bit sel, input logic v, input logic [2:0] u, input logic m);
    if (sel) begin b_valid = v; b_upc = u; b_mark = m; end
    else     begin a_valid = v; a_upc = u; a_mark = m; end
  endtask

  // Samples one whole frame (starting with the cycle after the accept edge).
  task automatic expect_frame(input bit sel, input logic [2:0] u, input logic m, input string name);
    int cpb;
    int bad_hs;
    logic [6:0] bits;
    logic [27:0] obs;
    logic [27:0] expw;
    cpb = sel ? CPB_B : CPB_A;
    bits = line_bits(u, m);
    obs = '0;
    expw = '0;
    bad_hs = 0;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        obs[b*cpb+c]  = tx_of(sel);
        expw[b*cpb+c] = bits[b];
        if (busy_of(sel) !== 1'b1 || ready_of(sel) !== 1'b0) bad_hs++;
      end
    end
    n_chk++;
    if (obs !== expw) begin
      n_fail++;
      $display("FAIL %s waveform: got %b expected %b", name, obs, expw);
    end
    n_chk++;
    if (bad_hs != 0) begin
      n_fail++;
      $display("FAIL %s busy/ready during frame: %0d bad cycles, expected 0", name, bad_hs);
    end
  endtask

  // One idle cycle: line high, ready, not busy, counter at the model's value.
  task automatic idle_check(input bit sel, input string name);
    logic [CNT_W+2:0] got, want;
    int ec;
    @(negedge clk);
    ec = sel ? exp_cnt_b : exp_cnt_a;
    got  = {tx_of(sel), ready_of(sel), busy_of(sel), cnt_of(sel)};
    want = {1'b1, 1'b1, 1'b0, CNT_W'(ec % (1 << CNT_W))};
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s idle {tx,ready,busy,cnt}: got %b expected %b", name, got, want);
    end
  endtask

  // Called at an idle negedge: offer u/m, after the accept edge either keep
  // valid with the next values or drop it, then check the frame and the idle cycle.
  task automatic send_frame(input bit sel, input logic [2:0] u, input logic m,
                            input logic keep, input logic [2:0] nu, input logic nm,
                            input string name);
    drive(sel, 1'b1, u, m);
    @(posedge clk);
    #1;
    drive(sel, keep, nu, nm);
    expect_frame(sel, u, m, name);
    if (sel) exp_cnt_b++; else exp_cnt_a++;
    idle_check(sel, name);
  endtask

  task automatic test_reset();
    logic [CNT_W*2+5:0] got;
    rst_n = 1'b0;
    drive(0, 1'b0, 3'b000, 1'b0);
    drive(1, 1'b0, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {a_tx, a_ready, a_busy, a_cnt, b_tx, b_ready, b_busy, b_cnt};
    n_chk++;
    if (got !== {1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %b", got);
    end
    rst_n = 1'b1;
    repeat (4) begin
      idle_check(0, "idle_hold_a");
      idle_check(1, "idle_hold_b");
    end
  endtask

  task automatic test_single();
    send_frame(0, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, "single_101");
  endtask

  task automatic test_back_to_back();
    send_frame(0, 3'b011, 1'b1, 1'b1, 3'b011, 1'b1, "b2b_frame1");
    send_frame(0, 3'b011, 1'b1, 1'b0, 3'b000, 1'b0, "b2b_frame2");
  endtask

  task automatic test_change_while_busy();
    send_frame(0, 3'b001, 1'b0, 1'b1, 3'b110, 1'b1, "busy_change_f1");
    send_frame(0, 3'b110, 1'b1, 1'b0, 3'b000, 1'b0, "busy_change_f2");
  endtask

  task automatic test_random();
    logic [2:0] u;
    logic m;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) idle_check(0, "rand_gap");
      u = 3'($urandom);
      m = 1'($urandom);
      send_frame(0, u, m, 1'b0, 3'($urandom), 1'($urandom), "rand_frame");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [CNT_W+2:0] got;
    // C=0 so the line is low in cycle 10 (third bit) before reset hits.
    drive(0, 1'b1, 3'b110, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'b000, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    n_chk++;
    if (a_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_frame_pre_reset tx: got %b expected 0", a_tx);
    end
    rst_n = 1'b0;
    #1;
    got = {a_tx, a_ready, a_busy, a_cnt};
    n_chk++;
    if (got !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_frame_reset {tx,ready,busy,cnt}: got %b expected %b",
               got, {1'b1, 1'b1, 1'b0, 8'd0});
    end
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, "after_reset_idle");
    idle_check(1, "after_reset_idle_b");
    send_frame(0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0, "after_reset_frame");
  endtask

  task automatic test_wrap();
    logic [2:0] us [0:256];
    logic       ms [0:256];
    for (int i = 0; i <= 256; i++) begin
      us[i] = 3'($urandom);
      ms[i] = 1'($urandom);
    end
    for (int i = 0; i < 256; i++) begin
      send_frame(1, us[i], ms[i], (i < 255), us[i+1], ms[i+1], "wrap_frame");
      if (i == 254) begin
        n_chk++;
        if (b_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_at_255: got %0d expected 255", b_cnt);
        end
      end
    end
    n_chk++;
    if (b_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_to_0: got %0d expected 0", b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_change_while_busy();
    test_random();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
